// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: merges ibus/dbus onto one QSPI adapter port with address decode and a one-word ibuf
module wb_mem_arbiter #(
  parameter logic [7:0] ROM_PAGE = 8'h00,
  parameter logic [7:0] RAM_PAGE = 8'h01,
  parameter bit         IBUF_EN  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ibus_stb_i,
  input  logic [31:0] ibus_adr_i,
  output logic        ibus_ack_o,
  output logic [31:0] ibus_dat_o,
  input  logic        dbus_stb_i,
  input  logic        dbus_we_i,
  input  logic [3:0]  dbus_be_i,
  input  logic [31:0] dbus_adr_i,
  input  logic [31:0] dbus_dat_i,
  output logic        dbus_ack_o,
  output logic [31:0] dbus_dat_o,
  output logic        mem_sel_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [21:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack_i
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MEM   = 2'd1;
  localparam logic [1:0] S_LOCAL = 2'd2;
  logic [1:0]  r_state;
  logic        r_gnt_d;
  logic        r_last_d;
  logic        r_mem_sel;
  logic        r_mem_stb;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [21:0] r_mem_adr;
  logic [31:0] r_mem_dat;
  logic [29:0] r_req_tag;
  logic [31:0] r_loc_dat;
  logic        r_ibuf_valid;
  logic [29:0] r_ibuf_tag;
  logic [31:0] r_ibuf_dat;
  logic        w_req;
  logic        w_pick_d;
  logic [31:0] w_adr;
  logic        w_we;
  logic        w_rom;
  logic        w_ram;
  logic        w_hit;
  logic        w_local;
  logic        w_ack;
  logic [31:0] w_dat;
  logic        w_unused;
  // Round-robin pick plus address decode/classification of the request seen in IDLE
  always_comb begin
    w_req    = ibus_stb_i | dbus_stb_i;
    w_pick_d = dbus_stb_i & (~ibus_stb_i | ~r_last_d);
    w_adr    = w_pick_d ? dbus_adr_i : ibus_adr_i;
    w_we     = w_pick_d & dbus_we_i;
    w_rom    = w_adr[31:24] == ROM_PAGE;
    w_ram    = w_adr[31:24] == RAM_PAGE;
    w_hit    = IBUF_EN & ~w_pick_d & r_ibuf_valid & (r_ibuf_tag == w_adr[31:2]);
    w_local  = w_hit | ~(w_rom | w_ram) | (w_we & w_rom);
    w_ack    = (r_state == S_MEM & mem_ack_i) | r_state == S_LOCAL;
    w_dat    = r_state == S_MEM ? mem_dat_i : r_loc_dat;
    w_unused = ^w_adr[1:0];
  end
  // Grant/capture in IDLE, wait for the adapter in MEM, single-cycle answer in LOCAL
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_gnt_d      <= 1'b0;
      r_last_d     <= 1'b0;
      r_mem_sel    <= 1'b1;
      r_mem_stb    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= '0;
      r_mem_adr    <= '0;
      r_mem_dat    <= '0;
      r_req_tag    <= '0;
      r_loc_dat    <= '0;
      r_ibuf_valid <= 1'b0;
      r_ibuf_tag   <= '0;
      r_ibuf_dat   <= '0;
    end else if (r_state == S_IDLE && w_req) begin
      r_gnt_d   <= w_pick_d;
      r_last_d  <= w_pick_d;
      r_mem_sel <= w_ram;
      r_mem_stb <= ~w_local;
      r_mem_we  <= w_we;
      r_mem_be  <= w_pick_d ? dbus_be_i : 4'hf;
      r_mem_adr <= w_adr[23:2];
      r_mem_dat <= w_pick_d ? dbus_dat_i : '0;
      r_req_tag <= w_adr[31:2];
      r_loc_dat <= w_hit ? r_ibuf_dat : '0;
      r_state   <= w_local ? S_LOCAL : S_MEM;
      if (w_we && w_adr[31:2] == r_ibuf_tag) r_ibuf_valid <= 1'b0;
    end else if (r_state == S_MEM && mem_ack_i) begin
      r_mem_stb <= 1'b0;
      r_state   <= S_IDLE;
      if (IBUF_EN && !r_gnt_d) begin
        r_ibuf_valid <= 1'b1;
        r_ibuf_tag   <= r_req_tag;
        r_ibuf_dat   <= mem_dat_i;
      end
    end else if (r_state == S_LOCAL) r_state <= S_IDLE;
  assign ibus_ack_o = w_ack & ~r_gnt_d;
  assign dbus_ack_o = w_ack & r_gnt_d;
  assign ibus_dat_o = ibus_ack_o ? w_dat : '0;
  assign dbus_dat_o = dbus_ack_o ? w_dat : '0;
  assign mem_sel_o  = r_mem_sel;
  assign mem_stb_o  = r_mem_stb;
  assign mem_we_o   = r_mem_we;
  assign mem_be_o   = r_mem_be;
  assign mem_adr_o  = r_mem_adr;
  assign mem_dat_o  = r_mem_dat;
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: scoreboard bench with adapter model for wb_mem_arbiter
module tb_wb_mem_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ibus_stb_i = 1'b0;
  logic [31:0] ibus_adr_i = '0;
  logic        ibus_ack_o;
  logic [31:0] ibus_dat_o;
  logic        dbus_stb_i = 1'b0;
  logic        dbus_we_i = 1'b0;
  logic [3:0]  dbus_be_i = '0;
  logic [31:0] dbus_adr_i = '0;
  logic [31:0] dbus_dat_i = '0;
  logic        dbus_ack_o;
  logic [31:0] dbus_dat_o;
  logic        mem_sel_o;
  logic        mem_stb_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [21:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic [31:0] mem_dat_i = '0;
  logic        mem_ack_i = 1'b0;

  typedef struct {bit d; logic [31:0] dat; int lat; int t0;} ack_t;
  typedef struct {logic sel; logic we; logic [3:0] be; logic [21:0] adr; logic [31:0] dat;} mem_t;
  ack_t sb[$];
  mem_t mq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int mem_lat = 8;
  int s0;

  wb_mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ibus_stb_i(ibus_stb_i), .ibus_adr_i(ibus_adr_i), .ibus_ack_o(ibus_ack_o), .ibus_dat_o(ibus_dat_o),
    .dbus_stb_i(dbus_stb_i), .dbus_we_i(dbus_we_i), .dbus_be_i(dbus_be_i), .dbus_adr_i(dbus_adr_i),
    .dbus_dat_i(dbus_dat_i), .dbus_ack_o(dbus_ack_o), .dbus_dat_o(dbus_dat_o),
    .mem_sel_o(mem_sel_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // adapter model: ack after mem_lat cycles of stb; ROM word 4 holds DEADBEEF, else {C0|sel, 00, adr}
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (mem_stb_o && !mem_ack_i) begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_ack_i = 1'b1;
          mem_dat_i = (!mem_sel_o && mem_adr_o == 22'h4) ? 32'hDEADBEEF : {7'h60, mem_sel_o, 2'b00, mem_adr_o};
          cnt = 0;
        end
      end else begin
        mem_ack_i = 1'b0;
        mem_dat_i = '0;
        cnt = 0;
      end
    end
  end

  // ack monitor
  initial forever begin
    @(negedge clk_i);
    if (ibus_ack_o || dbus_ack_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: ibus_ack=%0b dbus_ack=%0b at cycle %0d", ibus_ack_o, dbus_ack_o, cyc);
      end else begin
        ack_t e;
        logic [31:0] got;
        e = sb.pop_front();
        got = dbus_ack_o ? dbus_dat_o : ibus_dat_o;
        if ((ibus_ack_o && dbus_ack_o) || dbus_ack_o != e.d || got != e.dat ||
            (dbus_ack_o ? ibus_dat_o : dbus_dat_o) != 32'h0 || (e.lat >= 0 && cyc - e.t0 != e.lat)) begin
          errors++;
          $display("FAIL ack: got dbus=%0b dat=%h lat=%0d, required dbus=%0b dat=%h lat=%0d",
                   dbus_ack_o, got, cyc - e.t0, e.d, e.dat, e.lat);
        end
      end
    end
  end

  // adapter-port monitor: every new mem_stb_o must carry the expected request
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (mem_stb_o && !prev) begin
        starts++;
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_mem: sel=%0b we=%0b adr=%h", mem_sel_o, mem_we_o, mem_adr_o);
        end else begin
          mem_t m;
          m = mq.pop_front();
          if ({mem_sel_o, mem_we_o, mem_be_o, mem_adr_o, mem_dat_o} != {m.sel, m.we, m.be, m.adr, m.dat}) begin
            errors++;
            $display("FAIL mem_req: got sel=%0b we=%0b be=%h adr=%h dat=%h, required sel=%0b we=%0b be=%h adr=%h dat=%h",
                     mem_sel_o, mem_we_o, mem_be_o, mem_adr_o, mem_dat_o, m.sel, m.we, m.be, m.adr, m.dat);
          end
        end
      end
      prev = mem_stb_o;
    end
  end

  function automatic void exp_ack(bit d, logic [31:0] dat, int lat);
    sb.push_back('{d, dat, lat, cyc});
  endfunction

  function automatic void exp_mem(logic sel, logic we, logic [3:0] be, logic [21:0] adr, logic [31:0] dat);
    mq.push_back('{sel, we, be, adr, dat});
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic ibus_req(input logic [31:0] a);
    int n;
    ibus_adr_i = a;
    ibus_stb_i = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (ibus_ack_o) break;
    end
    if (n == 200) begin
      checks++;
      errors++;
      $display("FAIL ibus_timeout: no ack for adr %h", a);
    end
    @(posedge clk_i);
    #1;
    ibus_stb_i = 1'b0;
  endtask

  task automatic dbus_req(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    int n;
    dbus_we_i = we;
    dbus_be_i = be;
    dbus_adr_i = a;
    dbus_dat_i = d;
    dbus_stb_i = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (dbus_ack_o) break;
    end
    if (n == 200) begin
      checks++;
      errors++;
      $display("FAIL dbus_timeout: no ack for adr %h", a);
    end
    @(posedge clk_i);
    #1;
    dbus_stb_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_acks", {62'h0, ibus_ack_o, dbus_ack_o}, 64'h0);
    check("reset_mem_ctl", {58'h0, mem_sel_o, mem_stb_o, mem_we_o, mem_be_o[2:0]}, {58'h0, 6'b100000});
    check("reset_mem_be_adr", {38'h0, mem_be_o, mem_adr_o}, 64'h0);
    check("reset_mem_dat", {32'h0, mem_dat_o}, 64'h0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    // ROM fetch through the adapter, answered at +8
    mem_lat = 8;
    exp_mem(1'b0, 1'b0, 4'hf, 22'h4, 32'h0);
    exp_ack(1'b0, 32'hDEADBEEF, 8);
    ibus_req(32'h0000_0010);
    mem_lat = 3;
    // repeat fetch hits the buffer
    s0 = starts;
    exp_ack(1'b0, 32'hDEADBEEF, 1);
    ibus_req(32'h0000_0010);
    check("hit_no_mem", 64'(starts - s0), 64'h0);
    // byte store to RAM
    exp_mem(1'b1, 1'b1, 4'b1000, 22'h4, 32'hAA00_0000);
    exp_ack(1'b1, 32'hC100_0004, 3);
    dbus_req(1'b1, 4'b1000, 32'h0100_0013, 32'hAA00_0000);
    // ibus RAM fetch leaves last grant = ibus
    exp_mem(1'b1, 1'b0, 4'hf, 22'h8, 32'h0);
    exp_ack(1'b0, 32'hC100_0008, 3);
    ibus_req(32'h0100_0020);
    // both pending, last grant ibus: dbus first
    exp_mem(1'b1, 1'b0, 4'hf, 22'h10, 32'h0);
    exp_mem(1'b0, 1'b0, 4'hf, 22'hC, 32'h0);
    exp_ack(1'b1, 32'hC100_0010, 3);
    exp_ack(1'b0, 32'hC000_000C, -1);
    fork
      ibus_req(32'h0000_0030);
      dbus_req(1'b0, 4'hf, 32'h0100_0040, 32'h0);
    join
    // unmapped read: local zero at +1, sets last grant = dbus
    s0 = starts;
    exp_ack(1'b1, 32'h0, 1);
    dbus_req(1'b0, 4'hf, 32'h0200_0000, 32'h0);
    check("unmapped_no_mem", 64'(starts - s0), 64'h0);
    // both pending, last grant dbus: ibus first
    exp_mem(1'b0, 1'b0, 4'hf, 22'hD, 32'h0);
    exp_mem(1'b1, 1'b1, 4'hf, 22'h11, 32'h1234_5678);
    exp_ack(1'b0, 32'hC000_000D, 3);
    exp_ack(1'b1, 32'hC100_0011, -1);
    fork
      ibus_req(32'h0000_0034);
      dbus_req(1'b1, 4'hf, 32'h0100_0044, 32'h1234_5678);
    join
    // refill buffer with 0x10 (tag was 0x34)
    exp_mem(1'b0, 1'b0, 4'hf, 22'h4, 32'h0);
    exp_ack(1'b0, 32'hDEADBEEF, 3);
    ibus_req(32'h0000_0010);
    // ROM write is dropped locally and invalidates the buffer
    s0 = starts;
    exp_ack(1'b1, 32'h0, 1);
    dbus_req(1'b1, 4'hf, 32'h0000_0010, 32'h0000_0055);
    check("rom_write_no_mem", 64'(starts - s0), 64'h0);
    s0 = starts;
    exp_mem(1'b0, 1'b0, 4'hf, 22'h4, 32'h0);
    exp_ack(1'b0, 32'hDEADBEEF, 3);
    ibus_req(32'h0000_0010);
    check("refetch_after_rom_write", 64'(starts - s0), 64'h1);
    // async reset while waiting on the adapter
    mem_lat = 100;
    exp_mem(1'b1, 1'b0, 4'hf, 22'h14, 32'h0);
    ibus_adr_i = 32'h0100_0050;
    ibus_stb_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #2;
    check("mem_stb_before_rst", {63'h0, mem_stb_o}, 64'h1);
    rst_i = 1'b1;
    #1;
    check("rst_drops_stb", {62'h0, mem_stb_o, ibus_ack_o}, 64'h0);
    @(posedge clk_i);
    #1;
    ibus_stb_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    mem_lat = 3;
    // buffer was invalidated by reset
    s0 = starts;
    exp_mem(1'b0, 1'b0, 4'hf, 22'h4, 32'h0);
    exp_ack(1'b0, 32'hDEADBEEF, 3);
    ibus_req(32'h0000_0010);
    check("refetch_after_rst", 64'(starts - s0), 64'h1);
    repeat (3) @(posedge clk_i);
    check("ack_queue_empty", 64'(sb.size()), 64'h0);
    check("mem_queue_empty", 64'(mq.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
